// File: rtl/toy_bus_slv_node_param.sv
//============================================================================
// Module      : toy_bus_slv_node_param
// Description : Core-side bus slave node. Decodes the request address over
//               NUM_WIN programmable windows into a fabric target ID. The
//               request path is registered through a 2-entry skid buffer,
//               and the number of in-flight requests is bounded. Acks that
//               are not addressed to this node, or that arrive with nothing
//               outstanding, are consumed and reported on stray_ack.
// Ports       : clk, rst_n                      clock, async active-low reset
//               in0_req_*  (vld/rdy/addr/data/strb/opcode)  core request
//               in0_ack_*  (vld/rdy/data)                   core ack
//               out0_req_* (vld/rdy/addr/data/strb/opcode/src_id/tgt_id)
//                                                           fabric request
//               out0_ack_* (vld/rdy/opcode/data/src_id/tgt_id) fabric ack
//               outst_cnt                       current in-flight count
//               stray_ack                       1-cycle stray-ack pulse
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module toy_bus_slv_node_param #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int ID_W        = 4,
    parameter int SRC_ID      = 1,
    parameter int NUM_WIN     = 4,
    parameter logic [NUM_WIN*ADDR_W-1:0] WIN_BASE  =
        {32'hC000_0000, 32'h1000_0000, 32'h8000_0000, 32'h8000_0000},
    parameter logic [NUM_WIN*ADDR_W-1:0] WIN_LIMIT =
        {32'hC000_FFFF, 32'h1000_0000, 32'hA000_0000, 32'h9000_0000},
    parameter logic [NUM_WIN*ID_W-1:0]   WIN_TGT   =
        {4'd7, 4'd6, 4'd5, 4'd2},
    parameter int DEFAULT_TGT = 4,
    parameter int MAX_OUTST   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  in0_req_vld,
    output logic                  in0_req_rdy,
    input  logic [ADDR_W-1:0]     in0_req_addr,
    input  logic [DATA_W-1:0]     in0_req_data,
    input  logic [DATA_W/8-1:0]   in0_req_strb,
    input  logic                  in0_req_opcode,

    output logic                  in0_ack_vld,
    input  logic                  in0_ack_rdy,
    output logic [DATA_W-1:0]     in0_ack_data,

    output logic                  out0_req_vld,
    input  logic                  out0_req_rdy,
    output logic [ADDR_W-1:0]     out0_req_addr,
    output logic [DATA_W-1:0]     out0_req_data,
    output logic [DATA_W/8-1:0]   out0_req_strb,
    output logic                  out0_req_opcode,
    output logic [ID_W-1:0]       out0_req_src_id,
    output logic [ID_W-1:0]       out0_req_tgt_id,

    input  logic                  out0_ack_vld,
    output logic                  out0_ack_rdy,
    input  logic                  out0_ack_opcode,
    input  logic [DATA_W-1:0]     out0_ack_data,
    input  logic [ID_W-1:0]       out0_ack_src_id,
    input  logic [ID_W-1:0]       out0_ack_tgt_id,

    output logic [3:0]            outst_cnt,
    output logic                  stray_ack
);

    localparam int              STRB_W     = DATA_W / 8;
    localparam int              PLD_W      = ADDR_W + DATA_W + STRB_W + 1 + ID_W;
    localparam logic [ID_W-1:0] SRC_ID_V   = ID_W'(SRC_ID);
    localparam logic [ID_W-1:0] DEF_TGT_V  = ID_W'(DEFAULT_TGT);
    localparam logic [3:0]      MAX_CNT_V  = 4'(MAX_OUTST);

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_t;

    skid_state_t        state;
    skid_state_t        state_nxt;
    logic [PLD_W-1:0]   head;
    logic [PLD_W-1:0]   tail;
    logic [PLD_W-1:0]   in_pld;
    logic               head_ld_in;
    logic               head_ld_tail;
    logic               tail_ld;
    logic               req_rdy;
    logic               rdy_nxt;
    logic [3:0]         cnt;
    logic [3:0]         cnt_nxt;
    logic               in_hs;
    logic               out_hs;
    logic               ack_hs;
    logic               ack_ok;
    logic [NUM_WIN-1:0] win_hit;
    logic [ID_W-1:0]    dec_tgt;
    logic               unused_ack_fields;

    // Opcode and source ID of the returning ack carry no information this
    // node needs: returns are in order and the target ID alone qualifies them.
    assign unused_ack_fields = ^{out0_ack_opcode, out0_ack_src_id};

    //------------------------------------------------------------------------
    // Address decode. A window whose limit is not above its base has an
    // empty range, so the plain compare already never hits.
    //------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_WIN; gi++) begin : g_win
            logic [ADDR_W-1:0] base;
            logic [ADDR_W-1:0] limit;
            assign base        = WIN_BASE[gi*ADDR_W +: ADDR_W];
            assign limit       = WIN_LIMIT[gi*ADDR_W +: ADDR_W];
            assign win_hit[gi] = (in0_req_addr >= base) && (in0_req_addr < limit);
        end
    endgenerate

    // Scan from the top so the lowest-index hit is the last one written.
    always_comb begin
        dec_tgt = DEF_TGT_V;
        for (int i = NUM_WIN - 1; i >= 0; i--) begin
            if (win_hit[i]) begin
                dec_tgt = WIN_TGT[i*ID_W +: ID_W];
            end
        end
    end

    assign in_pld = {in0_req_addr, in0_req_data, in0_req_strb, in0_req_opcode, dec_tgt};

    //------------------------------------------------------------------------
    // Handshakes
    //------------------------------------------------------------------------
    assign in0_req_rdy  = req_rdy;
    assign out0_req_vld = (state != SKID_EMPTY);
    assign in_hs        = in0_req_vld && req_rdy;
    assign out_hs       = out0_req_vld && out0_req_rdy;

    //------------------------------------------------------------------------
    // Skid buffer FSM: head always holds the oldest entry and drives out0.
    //------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SKID_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        head_ld_in   = 1'b0;
        head_ld_tail = 1'b0;
        tail_ld      = 1'b0;
        case (state)
            SKID_EMPTY: begin
                if (in_hs) begin
                    state_nxt  = SKID_ONE;
                    head_ld_in = 1'b1;
                end
            end
            SKID_ONE: begin
                if (in_hs && out_hs) begin
                    head_ld_in = 1'b1;
                end else if (in_hs) begin
                    state_nxt = SKID_TWO;
                    tail_ld   = 1'b1;
                end else if (out_hs) begin
                    state_nxt = SKID_EMPTY;
                end
            end
            SKID_TWO: begin
                // in0 is never ready here, so only a drain can happen.
                if (out_hs) begin
                    state_nxt    = SKID_ONE;
                    head_ld_tail = 1'b1;
                end
            end
            default: begin
                state_nxt = SKID_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (head_ld_in) begin
                head <= in_pld;
            end else if (head_ld_tail) begin
                head <= tail;
            end
            if (tail_ld) begin
                tail <= in_pld;
            end
        end
    end

    assign {out0_req_addr, out0_req_data, out0_req_strb, out0_req_opcode, out0_req_tgt_id} = head;
    assign out0_req_src_id = SRC_ID_V;

    //------------------------------------------------------------------------
    // Ack filter: acks for this node with something outstanding pass straight
    // through; anything else is swallowed and flagged one cycle later.
    //------------------------------------------------------------------------
    assign ack_ok       = (out0_ack_tgt_id == SRC_ID_V) && (cnt != 4'd0);
    assign in0_ack_vld  = out0_ack_vld && ack_ok;
    assign in0_ack_data = out0_ack_data;
    assign out0_ack_rdy = ack_ok ? in0_ack_rdy : 1'b1;
    assign ack_hs       = in0_ack_vld && in0_ack_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stray_ack <= 1'b0;
        end else begin
            stray_ack <= out0_ack_vld && !ack_ok;
        end
    end

    //------------------------------------------------------------------------
    // Outstanding counter and registered request-ready. Ready is computed
    // from next-state values so it equals a function of the current
    // registers, yet stays low during reset and for the first edge after it.
    //------------------------------------------------------------------------
    always_comb begin
        cnt_nxt = cnt;
        if (in_hs && !ack_hs) begin
            cnt_nxt = cnt + 4'd1;
        end else if (!in_hs && ack_hs) begin
            cnt_nxt = cnt - 4'd1;
        end
    end

    assign rdy_nxt = (state_nxt != SKID_TWO) && (cnt_nxt < MAX_CNT_V);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= 4'd0;
            req_rdy <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            req_rdy <= rdy_nxt;
        end
    end

    assign outst_cnt = cnt;

endmodule

`default_nettype wire
